// File: rtl/cat_tx_deframer.sv
// AD9361 TX-port deframer: checks TX_FRAME alignment on the IDDR-captured 12-bit DDR stream
// and recovers SISO/MIMO I/Q samples with a strobe. Define CAT_DEFRAME_ERR_CNT_EN to add err_cnt.
module cat_tx_deframer #(
  parameter int DATA_W      = 12,
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_W       = 16
) (
  input  logic              rx_clk_bufr,
  input  logic              radio_rst,
  input  logic              mimo,
  input  logic              frame_r,
  input  logic              frame_f,
  input  logic [DATA_W-1:0] data_r,
  input  logic [DATA_W-1:0] data_f,
  output logic [DATA_W-1:0] i0,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] i1,
  output logic [DATA_W-1:0] q1,
  output logic              stb,
  output logic              locked,
  output logic              frame_err
`ifdef CAT_DEFRAME_ERR_CNT_EN
  ,output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  if (LOCK_CYCLES < 1 || ERR_W < 1) begin : g_param_check
    $error("cat_tx_deframer: LOCK_CYCLES and ERR_W must be >= 1");
  end

  state_t             state_q;
  logic               mimo_q;
  logic               prev_00_q;   // previous cycle carried frame pattern 2'b00
  logic               phase_q;     // MIMO: 0 = expecting ch0 (11), 1 = expecting ch1 (00)
  logic [CNT_W-1:0]   lock_cnt_q;
  logic [DATA_W-1:0]  hold_i_q, hold_q_q;
  logic [DATA_W-1:0]  i0_q, q0_q, i1_q, q1_q;
  logic               stb_q, locked_q, frame_err_q;

  logic [1:0]         frame_pat;
  logic               mode_chg;
  logic               pat_ok;
  logic [CNT_W-1:0]   lock_cnt_d;
  logic               cnt_hit;

  assign frame_pat  = {frame_r, frame_f};
  assign mode_chg   = (mimo != mimo_q);
  assign pat_ok     = mimo ? (frame_pat == (phase_q ? 2'b00 : 2'b11)) : (frame_pat == 2'b10);
  assign lock_cnt_d = lock_cnt_q + CNT_W'(1);
  assign cnt_hit    = (lock_cnt_d == CNT_W'(LOCK_CYCLES));

`ifdef CAT_DEFRAME_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent races between them.
  always_ff @(posedge rx_clk_bufr or posedge radio_rst) begin
    if (radio_rst) begin
      state_q     <= HUNT;
      mimo_q      <= 1'b0;
      prev_00_q   <= 1'b0;
      phase_q     <= 1'b0;
      lock_cnt_q  <= '0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      i0_q        <= '0;
      q0_q        <= '0;
      i1_q        <= '0;
      q1_q        <= '0;
      stb_q       <= 1'b0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef CAT_DEFRAME_ERR_CNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      mimo_q      <= mimo;
      prev_00_q   <= (frame_pat == 2'b00);
      stb_q       <= 1'b0;
      frame_err_q <= 1'b0;

      if (mode_chg) begin
        // A mode switch re-hunts silently and outranks any framing violation.
        state_q    <= HUNT;
        locked_q   <= 1'b0;
        lock_cnt_q <= '0;
        phase_q    <= 1'b0;
        hold_i_q   <= '0;
        hold_q_q   <= '0;
      end else if (state_q == HUNT) begin
        if (!mimo) begin
          if (frame_pat == 2'b10) begin
            if (cnt_hit) begin
              state_q    <= LOCKED;
              locked_q   <= 1'b1;
              lock_cnt_q <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_d;
            end
          end else begin
            lock_cnt_q <= '0;
          end
        end else if (frame_pat == 2'b11 && prev_00_q) begin
          phase_q <= 1'b1;
        end else if (frame_pat == 2'b00 && phase_q) begin
          phase_q <= 1'b0;
          if (cnt_hit) begin
            state_q    <= LOCKED;
            locked_q   <= 1'b1;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_d;
          end
        end else begin
          phase_q    <= 1'b0;
          lock_cnt_q <= '0;
        end
      end else if (pat_ok) begin
        if (!mimo) begin
          i0_q  <= data_r;
          q0_q  <= data_f;
          i1_q  <= data_r;
          q1_q  <= data_f;
          stb_q <= 1'b1;
        end else if (!phase_q) begin
          hold_i_q <= data_r;
          hold_q_q <= data_f;
          phase_q  <= 1'b1;
        end else begin
          i0_q    <= hold_i_q;
          q0_q    <= hold_q_q;
          i1_q    <= data_r;
          q1_q    <= data_f;
          stb_q   <= 1'b1;
          phase_q <= 1'b0;
        end
      end else begin
        frame_err_q <= 1'b1;
        state_q     <= HUNT;
        locked_q    <= 1'b0;
        lock_cnt_q  <= '0;
        phase_q     <= 1'b0;
        hold_i_q    <= '0;
        hold_q_q    <= '0;
`ifdef CAT_DEFRAME_ERR_CNT_EN
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
`endif
      end
    end
  end

  assign i0        = i0_q;
  assign q0        = q0_q;
  assign i1        = i1_q;
  assign q1        = q1_q;
  assign stb       = stb_q;
  assign locked    = locked_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cat_tx_deframer.sv
// Directed self-checking bench for cat_tx_deframer (SISO/MIMO lock, capture, errors, mode change, reset).
// err_cnt checks are compiled only when CAT_DEFRAME_ERR_CNT_EN is defined.
module tb_cat_tx_deframer;

  localparam int DW = 12;

  logic          rx_clk_bufr = 1'b0;
  logic          radio_rst;
  logic          mimo;
  logic          frame_r, frame_f;
  logic [DW-1:0] data_r, data_f;
  logic [DW-1:0] i0, q0, i1, q1;
  logic          stb, locked, frame_err;
`ifdef CAT_DEFRAME_ERR_CNT_EN
  logic [1:0]    err_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 rx_clk_bufr = ~rx_clk_bufr;

  cat_tx_deframer #(.DATA_W(DW), .LOCK_CYCLES(4), .ERR_W(2)) dut (
    .rx_clk_bufr (rx_clk_bufr),
    .radio_rst   (radio_rst),
    .mimo        (mimo),
    .frame_r     (frame_r),
    .frame_f     (frame_f),
    .data_r      (data_r),
    .data_f      (data_f),
    .i0          (i0),
    .q0          (q0),
    .i1          (i1),
    .q1          (q1),
    .stb         (stb),
    .locked      (locked),
    .frame_err   (frame_err)
`ifdef CAT_DEFRAME_ERR_CNT_EN
    ,.err_cnt    (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one input cycle, then sample 1 ns after the capturing edge.
  task automatic step(input logic [1:0] fp, input logic [DW-1:0] dr, input logic [DW-1:0] df);
    @(negedge rx_clk_bufr);
    {frame_r, frame_f} = fp;
    data_r = dr;
    data_f = df;
    @(posedge rx_clk_bufr);
    #1;
  endtask

  task automatic check_samples(input string tag, input logic [DW-1:0] ei0, input logic [DW-1:0] eq0,
                               input logic [DW-1:0] ei1, input logic [DW-1:0] eq1);
    check({tag, ".i0"}, 32'(i0), 32'(ei0));
    check({tag, ".q0"}, 32'(q0), 32'(eq0));
    check({tag, ".i1"}, 32'(i1), 32'(ei1));
    check({tag, ".q1"}, 32'(q1), 32'(eq1));
  endtask

  // Stray 00 to arm, then four clean 11/00 periods; locked must rise only after the fourth.
  task automatic relock_mimo(input string tag);
    step(2'b00, 12'h000, 12'h000);
    for (int p = 0; p < 4; p++) begin
      step(2'b11, 12'h0A0, 12'h0B0);
      check({tag, ".stb_hunt11"}, 32'(stb), 32'd0);
      step(2'b00, 12'h0C0, 12'h0D0);
      check({tag, ".locked_p"}, 32'(locked), (p == 3) ? 32'd1 : 32'd0);
      check({tag, ".stb_hunt00"}, 32'(stb), 32'd0);
    end
  endtask

  initial begin
    int stb_seen;
    radio_rst = 1'b1;
    mimo      = 1'b0;
    {frame_r, frame_f} = 2'b00;
    data_r = '0;
    data_f = '0;
    repeat (2) @(posedge rx_clk_bufr);
    #1;
    check("rst.stb", 32'(stb), 32'd0);
    check("rst.locked", 32'(locked), 32'd0);
    check("rst.frame_err", 32'(frame_err), 32'd0);
    check_samples("rst", 12'h000, 12'h000, 12'h000, 12'h000);
`ifdef CAT_DEFRAME_ERR_CNT_EN
    check("rst.err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge rx_clk_bufr);
    radio_rst = 1'b0;

    // SISO lock and capture
    for (int c = 1; c <= 4; c++) begin
      step(2'b10, 12'h123, 12'h456);
      check("siso.locked_hunt", 32'(locked), (c == 4) ? 32'd1 : 32'd0);
      check("siso.stb_hunt", 32'(stb), 32'd0);
    end
    for (int c = 5; c <= 7; c++) begin
      step(2'b10, 12'h123, 12'h456);
      check("siso.stb", 32'(stb), 32'd1);
      check_samples("siso", 12'h123, 12'h456, 12'h123, 12'h456);
    end
    step(2'b10, 12'h7AB, 12'h0CD);
    check_samples("siso2", 12'h7AB, 12'h0CD, 12'h7AB, 12'h0CD);

    // Locked SISO -> MIMO: silent re-hunt
    mimo = 1'b1;
    step(2'b00, 12'h000, 12'h000);
    check("mode.locked", 32'(locked), 32'd0);
    check("mode.frame_err", 32'(frame_err), 32'd0);
    check("mode.stb", 32'(stb), 32'd0);
    check_samples("mode_hold", 12'h7AB, 12'h0CD, 12'h7AB, 12'h0CD);
`ifdef CAT_DEFRAME_ERR_CNT_EN
    check("mode.err_cnt", 32'(err_cnt), 32'd0);
`endif
    for (int p = 0; p < 4; p++) begin
      step(2'b11, 12'h111, 12'h222);
      step(2'b00, 12'h333, 12'h444);
      check("mimo.locked_p", 32'(locked), (p == 3) ? 32'd1 : 32'd0);
      check("mimo.stb_hunt", 32'(stb), 32'd0);
    end

    // MIMO capture: stb every second cycle
    step(2'b11, 12'h111, 12'h222);
    check("mimo.stb_ch0", 32'(stb), 32'd0);
    step(2'b00, 12'h333, 12'h444);
    check("mimo.stb_ch1", 32'(stb), 32'd1);
    check_samples("mimo", 12'h111, 12'h222, 12'h333, 12'h444);
    step(2'b11, 12'hAAA, 12'hBBB);
    check("mimo.stb_gap", 32'(stb), 32'd0);
    check_samples("mimo_hold", 12'h111, 12'h222, 12'h333, 12'h444);
    step(2'b00, 12'hCCC, 12'hDDD);
    check("mimo.stb2", 32'(stb), 32'd1);
    check_samples("mimo2", 12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD);

    // Violation 11,11 while locked
    step(2'b11, 12'h555, 12'h666);
    step(2'b11, 12'h777, 12'h888);
    check("err.frame_err", 32'(frame_err), 32'd1);
    check("err.locked", 32'(locked), 32'd0);
    check("err.stb", 32'(stb), 32'd0);
    check_samples("err_hold", 12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD);
`ifdef CAT_DEFRAME_ERR_CNT_EN
    check("err.err_cnt", 32'(err_cnt), 32'd1);
`endif
    relock_mimo("relock1");
    check("relock1.frame_err_gone", 32'(frame_err), 32'd0);
    step(2'b11, 12'h121, 12'h232);
    step(2'b00, 12'h343, 12'h454);
    check("relock1.stb", 32'(stb), 32'd1);
    check_samples("relock1", 12'h121, 12'h232, 12'h343, 12'h454);

    // Four more violations (00 where 11 expected); 2-bit counter saturates at 3
    for (int v = 2; v <= 5; v++) begin
      if (v > 2) relock_mimo("relock_n");
      step(2'b00, 12'h000, 12'h000);
      check("sat.frame_err", 32'(frame_err), 32'd1);
`ifdef CAT_DEFRAME_ERR_CNT_EN
      check("sat.err_cnt", 32'(err_cnt), (v >= 3) ? 32'd3 : 32'(v));
`endif
    end

    // Invalid pattern coinciding with a mode change: no error
    relock_mimo("relock_mc");
    mimo = 1'b0;
    step(2'b11, 12'h000, 12'h000);
    check("mc_err.frame_err", 32'(frame_err), 32'd0);
    check("mc_err.locked", 32'(locked), 32'd0);
`ifdef CAT_DEFRAME_ERR_CNT_EN
    check("mc_err.err_cnt", 32'(err_cnt), 32'd3);
`endif

    // Reset mid MIMO pair
    mimo = 1'b1;
    relock_mimo("relock_rst");
    step(2'b11, 12'hF0F, 12'h0F0);
    @(negedge rx_clk_bufr);
    radio_rst = 1'b1;
    #1;
    check("arst.locked", 32'(locked), 32'd0);
    check("arst.stb", 32'(stb), 32'd0);
    check_samples("arst", 12'h000, 12'h000, 12'h000, 12'h000);
`ifdef CAT_DEFRAME_ERR_CNT_EN
    check("arst.err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge rx_clk_bufr);
    radio_rst = 1'b0;
    // mimo_q restarts at 0, so this first cycle is itself a mode change
    step(2'b00, 12'hEEE, 12'hEEE);
    stb_seen = 0;
    step(2'b00, 12'h000, 12'h000);
    for (int p = 0; p < 4; p++) begin
      step(2'b11, 12'h246, 12'h357);
      stb_seen += int'(stb);
      step(2'b00, 12'h468, 12'h579);
      stb_seen += int'(stb);
      check("post_rst.locked_p", 32'(locked), (p == 3) ? 32'd1 : 32'd0);
    end
    check("post_rst.stb_hunt_count", 32'(stb_seen), 32'd0);
    step(2'b11, 12'h246, 12'h357);
    check("post_rst.stb_ch0", 32'(stb), 32'd0);
    step(2'b00, 12'h468, 12'h579);
    check("post_rst.stb", 32'(stb), 32'd1);
    check_samples("post_rst", 12'h246, 12'h357, 12'h468, 12'h579);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
